bist_checker: RTL

//  Downstream stage of the BIST sender: samples channel outputs after they cross the router/DUT
//  and compares them against a locally regenerated copy of the sender's LFSR pattern stream.

---
 rtl/bist_pkg.sv | 20 ++
 rtl/bist_pattern_gen.sv | 38 +++
 rtl/bist_checker.sv | 114 +++++++++++
 3 files changed

// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared types, widths and the lfsr32 step function for the BIST sender/checker pair
package bist_pkg;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int RNG_W = 32;
  localparam int CNT_W = 32;

  // Galois form of x^32 + x^22 + x^2 + x + 1
  localparam logic [RNG_W-1:0] LFSR_POLY = 32'h80200003;

  function automatic logic [RNG_W-1:0] lfsr32_next(input logic [RNG_W-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : '0);
  endfunction

endpackage

// File: rtl/bist_pattern_gen.sv
// rtl/bist_pattern_gen.sv - lfsr32 plus shift/merge pattern register, frozen after N_UPDATES edges
module bist_pattern_gen
  import bist_pkg::*;
#(
  parameter int               WIDTH     = 70,
  parameter logic [RNG_W-1:0] SEED      = 32'hdeadbeef,
  parameter int               N_UPDATES = 999
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic [WIDTH-1:0] o_pattern
);

  logic [RNG_W-1:0]       r_lfsr;
  logic [WIDTH-1:0]       r_pat;
  logic [CNT_W-1:0]       r_cnt;
  logic [WIDTH+RNG_W-1:0] w_merge;
  logic                   w_active;

  // Low WIDTH bits of {pat, rng}: shifts by 32 and also covers WIDTH < 32
  assign w_merge  = {r_pat, r_lfsr};
  assign w_active = (r_cnt < CNT_W'(N_UPDATES));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lfsr <= SEED;
      r_pat  <= '0;
      r_cnt  <= '0;
    end else if (w_active) begin
      r_lfsr <= lfsr32_next(r_lfsr);
      r_pat  <= w_merge[WIDTH-1:0];
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign o_pattern = r_pat;

endmodule

// File: rtl/bist_checker.sv
// rtl/bist_checker.sv - compares DUT outputs against a regenerated pattern stream, counts and captures failures
module bist_checker
  import bist_pkg::*;
#(
  parameter int                       TEST_CHANNELS = 70,
  parameter logic [RNG_W-1:0]         SEED          = 32'hdeadbeef,
  parameter int                       TEST_CASES    = 1000,
  parameter int                       LATENCY       = 2,
  parameter logic [TEST_CHANNELS-1:0] CHECK_MASK    = '1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [TEST_CHANNELS-1:0] input_channels,
  output logic                     done,
  output logic                     pass,
  output logic [CNT_W-1:0]         error_count,
  output logic [CNT_W-1:0]         first_fail_index,
  output logic [TEST_CHANNELS-1:0] first_fail_syndrome
);

  state_t                   r_state;
  state_t                   w_next_state;
  logic [CNT_W-1:0]         r_edge;
  logic [CNT_W-1:0]         r_err;
  logic [CNT_W-1:0]         r_ffi;
  logic [TEST_CHANNELS-1:0] r_ffs;
  logic                     r_done;
  logic [TEST_CHANNELS-1:0] w_exp;
  logic [TEST_CHANNELS-1:0] w_expected;
  logic [TEST_CHANNELS-1:0] w_syn;
  logic [CNT_W-1:0]         w_k;
  logic                     w_cmp;
  logic                     w_last;
  logic                     w_mismatch;

  bist_pattern_gen #(
    .WIDTH    (TEST_CHANNELS),
    .SEED     (SEED),
    .N_UPDATES(TEST_CASES - 1)
  ) u_gen (
    .i_clk    (clk),
    .i_rst    (~reset_n),
    .o_pattern(w_exp)
  );

  generate
    if (LATENCY > 0) begin : g_pipe
      logic [TEST_CHANNELS-1:0] r_pipe [LATENCY];
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < LATENCY; i++) r_pipe[i] <= '0;
        end else begin
          r_pipe[0] <= w_exp;
          for (int i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end
      assign w_expected = r_pipe[LATENCY-1];
    end else begin : g_nopipe
      assign w_expected = w_exp;
    end
  endgenerate

  // r_edge holds edges already counted, so the upcoming edge is r_edge+1
  assign w_k        = r_edge - CNT_W'(LATENCY);
  assign w_cmp      = (r_state == CHECK) || ((r_state == WAIT) && (r_edge == CNT_W'(LATENCY)));
  assign w_last     = (w_k == CNT_W'(TEST_CASES - 1));
  assign w_syn      = (input_channels ^ w_expected) & CHECK_MASK;
  assign w_mismatch = |w_syn;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= WAIT;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      WAIT: begin
        if (w_cmp && w_last)                                  w_next_state = DONE;
        else if (w_cmp || (r_edge == CNT_W'(LATENCY - 1)))    w_next_state = CHECK;
      end
      CHECK:   if (w_last) w_next_state = DONE;
      DONE:    w_next_state = DONE;
      default: w_next_state = WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edge <= '0;
      r_err  <= '0;
      r_ffi  <= '0;
      r_ffs  <= '0;
      r_done <= 1'b0;
    end else begin
      if (r_state != DONE) r_edge <= r_edge + 1'b1;
      if (w_cmp && w_last) r_done <= 1'b1;
      if (w_cmp && w_mismatch) begin
        if (r_err != '1) r_err <= r_err + 1'b1;
        if (r_err == '0) begin
          r_ffi <= w_k;
          r_ffs <= w_syn;
        end
      end
    end
  end

  assign done                = r_done;
  assign pass                = r_done && (r_err == '0);
  assign error_count         = r_err;
  assign first_fail_index    = r_ffi;
  assign first_fail_syndrome = r_ffs;

endmodule
